// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared encodings for the multicycle MIPS-subset controller:
//               FSM state codes, opcode/funct values and the select codes
//               driven onto the datapath (ALUOp, EXTOp, NPCOp, WDSel, ...).
//               Imported by mc_decode and mc_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

    typedef logic [2:0] mc_state_t;

    // FSM state encodings (also visible on state_o for debug)
    localparam mc_state_t c_st_if  = 3'd0;
    localparam mc_state_t c_st_id  = 3'd1;
    localparam mc_state_t c_st_exe = 3'd2;
    localparam mc_state_t c_st_mem = 3'd3;
    localparam mc_state_t c_st_wb  = 3'd4;

    // Opcodes, IR[31:26]
    localparam logic [5:0] c_op_r    = 6'b000000;
    localparam logic [5:0] c_op_addi = 6'b001000;
    localparam logic [5:0] c_op_andi = 6'b001100;
    localparam logic [5:0] c_op_ori  = 6'b001101;
    localparam logic [5:0] c_op_lw   = 6'b100011;
    localparam logic [5:0] c_op_sw   = 6'b101011;
    localparam logic [5:0] c_op_beq  = 6'b000100;
    localparam logic [5:0] c_op_j    = 6'b000010;

    // R-type function codes, IR[5:0]
    localparam logic [5:0] c_fn_add = 6'b100000;
    localparam logic [5:0] c_fn_sub = 6'b100010;
    localparam logic [5:0] c_fn_and = 6'b100100;
    localparam logic [5:0] c_fn_or  = 6'b100101;
    localparam logic [5:0] c_fn_slt = 6'b101010;

    // ALU function codes
    localparam logic [3:0] c_alu_and = 4'b0000;
    localparam logic [3:0] c_alu_or  = 4'b0001;
    localparam logic [3:0] c_alu_add = 4'b0010;
    localparam logic [3:0] c_alu_sub = 4'b0110;
    localparam logic [3:0] c_alu_slt = 4'b0111;

    // Immediate extender control
    localparam logic [1:0] c_ext_zero = 2'b00;
    localparam logic [1:0] c_ext_sign = 2'b01;

    // Next-PC source
    localparam logic [1:0] c_npc_plus4  = 2'b00;
    localparam logic [1:0] c_npc_branch = 2'b01;
    localparam logic [1:0] c_npc_jump   = 2'b10;

    // Register-file write data / destination selects
    localparam logic [1:0] c_wd_aluout = 2'b00;
    localparam logic [1:0] c_wd_mdr    = 2'b01;
    localparam logic [1:0] c_rd_rt     = 2'b00;
    localparam logic [1:0] c_rd_rd     = 2'b01;

    // ALU B-operand select
    localparam logic [1:0] c_srcb_rt   = 2'b00;
    localparam logic [1:0] c_srcb_four = 2'b01;
    localparam logic [1:0] c_srcb_imm  = 2'b10;

    // R-type funct to ALU code; unknown functs fall back to ADD so the
    // select is always driven (the decoder flags them illegal separately).
    function automatic logic [3:0] funct_to_alu(input logic [5:0] funct);
        logic [3:0] alu;
        case (funct)
            c_fn_add: alu = c_alu_add;
            c_fn_sub: alu = c_alu_sub;
            c_fn_and: alu = c_alu_and;
            c_fn_or:  alu = c_alu_or;
            c_fn_slt: alu = c_alu_slt;
            default:  alu = c_alu_add;
        endcase
        return alu;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_decode
// Description : Purely combinational Op/Funct classifier for the multicycle
//               controller. Produces one-hot instruction class flags, the
//               illegal-instruction flag, the immediate-extension mode and
//               the execute-stage ALU function.
// Ports       : i_op[5:0]      opcode from IR[31:26]
//               i_funct[5:0]   funct field from IR[5:0]
//               o_is_r         legal R-type (listed funct only)
//               o_is_ialu      addi / andi / ori
//               o_is_lw, o_is_sw, o_is_beq, o_is_j
//               o_illegal      none of the above
//               o_ext_op[1:0]  zero-extend for andi/ori, sign-extend else
//               o_alu_op[3:0]  ALU function for the EXE state
// Revision    : 1.0 - initial release
// ============================================================================
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output logic       o_is_r,
    output logic       o_is_ialu,
    output logic       o_is_lw,
    output logic       o_is_sw,
    output logic       o_is_beq,
    output logic       o_is_j,
    output logic       o_illegal,
    output logic [1:0] o_ext_op,
    output logic [3:0] o_alu_op
);

    logic w_funct_ok;

    always_comb begin
        w_funct_ok = 1'b0;
        o_is_r     = 1'b0;
        o_is_ialu  = 1'b0;
        o_is_lw    = 1'b0;
        o_is_sw    = 1'b0;
        o_is_beq   = 1'b0;
        o_is_j     = 1'b0;
        o_ext_op   = c_ext_sign;
        o_alu_op   = c_alu_add;

        case (i_funct)
            c_fn_add, c_fn_sub, c_fn_and, c_fn_or, c_fn_slt: w_funct_ok = 1'b1;
            default:                                         w_funct_ok = 1'b0;
        endcase

        case (i_op)
            c_op_r: begin
                o_is_r   = w_funct_ok;
                o_alu_op = funct_to_alu(i_funct);
            end
            c_op_addi: o_is_ialu = 1'b1;
            c_op_andi: begin
                o_is_ialu = 1'b1;
                o_ext_op  = c_ext_zero;
                o_alu_op  = c_alu_and;
            end
            c_op_ori: begin
                o_is_ialu = 1'b1;
                o_ext_op  = c_ext_zero;
                o_alu_op  = c_alu_or;
            end
            c_op_lw:  o_is_lw = 1'b1;
            c_op_sw:  o_is_sw = 1'b1;
            c_op_beq: begin
                o_is_beq = 1'b1;
                o_alu_op = c_alu_sub;
            end
            c_op_j:   o_is_j = 1'b1;
            default:  o_is_j = 1'b0;
        endcase

        o_illegal = ~(o_is_r | o_is_ialu | o_is_lw | o_is_sw | o_is_beq | o_is_j);
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multicycle main controller for the MIPS-subset CPU. Walks one
//               shared datapath through IF/ID/EXE/MEM/WB, driving every
//               enable and select, and stalls on the memory req/ready
//               handshake. Optional fetch/data wait timeout (IF_TIMEOUT > 0)
//               raises a sticky err_o.
// Ports       : clk, rstn (synchronous, active low)
//               Op, Funct, Zero, mem_ready               - inputs
//               mem_req, IorD, IRWrite, PCWrite, NPCOp,
//               RegWrite, MemWrite, RegDst, WDSel,
//               ALUSrcA, ALUSrcB, ALUOp, EXTOp           - datapath control
//               illegal_o, err_o, state_o                - status / debug
//               cyc_cnt, ins_cnt                         - perf counters
// Config      : macro MC_CTRL_PERF_EN adds cyc_cnt / ins_cnt outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int IF_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] NPCOp,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [1:0] RegDst,
    output logic [1:0] WDSel,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] EXTOp,
    output logic       illegal_o,
    output logic       err_o,
    output logic [2:0] state_o
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ins_cnt
`endif
);

    mc_state_t  r_state;
    mc_state_t  w_next_state;
    logic       r_err;
    logic       w_timeout;

    logic       w_is_r;
    logic       w_is_ialu;
    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_is_beq;
    logic       w_is_j;
    logic       w_illegal;
    logic [1:0] w_ext_op;
    logic [3:0] w_alu_op;

    mc_decode u_decode (
        .i_op      (Op),
        .i_funct   (Funct),
        .o_is_r    (w_is_r),
        .o_is_ialu (w_is_ialu),
        .o_is_lw   (w_is_lw),
        .o_is_sw   (w_is_sw),
        .o_is_beq  (w_is_beq),
        .o_is_j    (w_is_j),
        .o_illegal (w_illegal),
        .o_ext_op  (w_ext_op),
        .o_alu_op  (w_alu_op)
    );

    // ------------------------------------------------------------------
    // Memory wait timeout
    // ------------------------------------------------------------------
    generate
        if (IF_TIMEOUT > 0) begin : g_timeout
            localparam int c_cnt_w = (IF_TIMEOUT > 1) ? $clog2(IF_TIMEOUT) : 1;

            logic [c_cnt_w-1:0] r_wait_cnt;
            logic               w_waiting;

            assign w_waiting = ((r_state == c_st_if) || (r_state == c_st_mem)) && !mem_ready;
            // Fires on the IF_TIMEOUT-th consecutive unanswered cycle.
            assign w_timeout = w_waiting && (r_wait_cnt == c_cnt_w'(IF_TIMEOUT - 1));

            // A waiting cycle without timeout always stays in the same state,
            // so any other case (ready, timeout, state change) clears.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    r_wait_cnt <= '0;
                end else if (w_waiting && !w_timeout) begin
                    r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
                end else begin
                    r_wait_cnt <= '0;
                end
            end
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and sticky error registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= c_st_if;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        NPCOp        = c_npc_plus4;
        RegWrite     = 1'b0;
        MemWrite     = 1'b0;
        RegDst       = c_rd_rt;
        WDSel        = c_wd_aluout;
        ALUSrcA      = 1'b0;
        ALUSrcB      = c_srcb_four;
        ALUOp        = c_alu_add;
        EXTOp        = c_ext_sign;
        illegal_o    = 1'b0;

        case (r_state)
            c_st_if: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWrite      = 1'b1;
                    PCWrite      = 1'b1;
                    w_next_state = c_st_id;
                end
            end

            c_st_id: begin
                // ALU precomputes PC + (sign-extended imm) as branch target.
                ALUSrcB = c_srcb_imm;
                EXTOp   = w_ext_op;
                if (w_is_j) begin
                    PCWrite      = 1'b1;
                    NPCOp        = c_npc_jump;
                    w_next_state = c_st_if;
                end else if (w_illegal) begin
                    illegal_o    = 1'b1;
                    w_next_state = c_st_if;
                end else begin
                    w_next_state = c_st_exe;
                end
            end

            c_st_exe: begin
                ALUSrcA = 1'b1;
                EXTOp   = w_ext_op;
                ALUOp   = w_alu_op;
                if (w_is_r) begin
                    ALUSrcB      = c_srcb_rt;
                    w_next_state = c_st_wb;
                end else if (w_is_ialu) begin
                    ALUSrcB      = c_srcb_imm;
                    w_next_state = c_st_wb;
                end else if (w_is_lw || w_is_sw) begin
                    ALUSrcB      = c_srcb_imm;
                    w_next_state = c_st_mem;
                end else begin
                    // beq: subtract rs-rt, take the precomputed target on Zero.
                    ALUSrcB      = c_srcb_rt;
                    PCWrite      = Zero;
                    NPCOp        = c_npc_branch;
                    w_next_state = c_st_if;
                end
            end

            c_st_mem: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                EXTOp    = w_ext_op;
                MemWrite = w_is_sw && !w_timeout;
                if (mem_ready) begin
                    w_next_state = w_is_lw ? c_st_wb : c_st_if;
                end else if (w_timeout) begin
                    w_next_state = c_st_if;
                end
            end

            c_st_wb: begin
                RegWrite     = 1'b1;
                EXTOp        = w_ext_op;
                RegDst       = w_is_r  ? c_rd_rd  : c_rd_rt;
                WDSel        = w_is_lw ? c_wd_mdr : c_wd_aluout;
                w_next_state = c_st_if;
            end

            default: w_next_state = c_st_if;
        endcase

        // Reset aborts the current instruction: no strobe may leak out.
        if (!rstn) begin
            mem_req   = 1'b0;
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            RegWrite  = 1'b0;
            MemWrite  = 1'b0;
            illegal_o = 1'b0;
        end
    end

    assign err_o   = r_err;
    assign state_o = r_state;

`ifdef MC_CTRL_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_ins_cnt;
    logic        w_retire;

    // Any return to IF from a later state retires an instruction, except
    // a MEM access abandoned by timeout.
    assign w_retire = (r_state != c_st_if) && (w_next_state == c_st_if) && !w_timeout;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cyc_cnt <= '0;
            r_ins_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
            if (w_retire) begin
                r_ins_cnt <= r_ins_cnt + 32'd1;
            end
        end
    end

    assign cyc_cnt = r_cyc_cnt;
    assign ins_cnt = r_ins_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Scoreboard bench for mc_ctrl. A stimulus process expands each
//               instruction into its expected per-cycle control trace from
//               the ISA rules and queues it; a monitor pops one entry per
//               cycle on the falling edge and compares masked outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;
    import mc_pkg::*;

    localparam int IF_TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req, IorD, IRWrite, PCWrite, RegWrite, MemWrite;
    logic [1:0] NPCOp, RegDst, WDSel, ALUSrcB, EXTOp;
    logic       ALUSrcA, illegal_o, err_o;
    logic [3:0] ALUOp;
    logic [2:0] state_o;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cyc_cnt, ins_cnt;
`endif

    always #5 clk = ~clk;

    mc_ctrl #(.IF_TIMEOUT(IF_TIMEOUT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .Op        (Op),
        .Funct     (Funct),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .IorD      (IorD),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .NPCOp     (NPCOp),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .RegDst    (RegDst),
        .WDSel     (WDSel),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .EXTOp     (EXTOp),
        .illegal_o (illegal_o),
        .err_o     (err_o),
        .state_o   (state_o)
`ifdef MC_CTRL_PERF_EN
        ,
        .cyc_cnt   (cyc_cnt),
        .ins_cnt   (ins_cnt)
`endif
    );

    typedef struct packed {
        logic [2:0] st;
        logic       mreq, irw, pcw, rw, mw, ill, err, iord;
        logic [1:0] npc, rdst, wds, ext;
        logic [3:0] alu;
        logic       srca;
        logic [1:0] srcb;
    } obs_t;

    obs_t exp_q[$];
    obs_t msk_q[$];
    obs_t act, mon_e, mon_m;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic exp_err = 1'b0;
    logic [5:0] cur_op = '0;
    logic [5:0] cur_fn = '0;

    assign act = {state_o, mem_req, IRWrite, PCWrite, RegWrite, MemWrite, illegal_o, err_o,
                  IorD, NPCOp, RegDst, WDSel, EXTOp, ALUOp, ALUSrcA, ALUSrcB};

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one expected trace entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_m = msk_q.pop_front();
            n_vec++;
            if ((act & mon_m) !== (mon_e & mon_m)) begin
                n_err++;
                $display("FAIL ctrl cycle %0d op=%b: got %h, expected %h (mask %h)",
                         cyc, Op, act & mon_m, mon_e & mon_m, mon_m);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic obs_t base(input logic [2:0] st);
        obs_t e;
        e     = '0;
        e.st  = st;
        e.err = exp_err;
        return e;
    endfunction

    function automatic obs_t fetch_exp(input bit last);
        obs_t e;
        e      = base(3'd0);
        e.mreq = 1'b1;
        e.ext  = 2'b01;
        e.alu  = c_alu_add;
        e.srca = 1'b0;
        e.srcb = 2'b01;
        if (last) begin
            e.irw = 1'b1;
            e.pcw = 1'b1;
            e.npc = 2'b00;
        end
        return e;
    endfunction

    // Drive one cycle's inputs and queue what the outputs must be.
    // ce/ca enable checking of EXTOp and of the ALU operand/function selects.
    task automatic step(input obs_t e, input bit ce, input bit ca,
                        input logic rdy, input logic z, input logic rn);
        obs_t m;
        @(posedge clk);
        #1;
        rstn      = rn;
        mem_ready = rdy;
        Zero      = z;
        Op        = cur_op;
        Funct     = cur_fn;
        m = '0;
        m.st = '1; m.mreq = 1'b1; m.irw = 1'b1; m.pcw = 1'b1;
        m.rw = 1'b1; m.mw = 1'b1; m.ill = 1'b1; m.err = 1'b1;
        m.iord = e.mreq;
        m.npc  = {2{e.pcw}};
        m.rdst = {2{e.rw}};
        m.wds  = {2{e.rw}};
        m.ext  = {2{ce}};
        m.alu  = {4{ca}};
        m.srca = ca;
        m.srcb = {2{ca}};
        exp_q.push_back(e);
        msk_q.push_back(m);
    endtask

    // Expected trace of one instruction. iw/mwt: unanswered IF/MEM cycles
    // (mwt >= IF_TIMEOUT means the data access times out); rst_mem pulls
    // reset during the first MEM cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int iw, input int mwt, input bit rst_mem);
        obs_t       e;
        logic [3:0] r_alu;
        logic [1:0] ext;
        bit fn_ok, r_ty, ialu, lw, sw, beq, jmp, legal;
        cur_op = op;
        cur_fn = fn;
        fn_ok  = 1'b1;
        case (fn)
            6'b100000: r_alu = c_alu_add;
            6'b100010: r_alu = c_alu_sub;
            6'b100100: r_alu = c_alu_and;
            6'b100101: r_alu = c_alu_or;
            6'b101010: r_alu = c_alu_slt;
            default: begin fn_ok = 1'b0; r_alu = c_alu_add; end
        endcase
        r_ty  = (op == 6'b000000) && fn_ok;
        ialu  = (op == 6'b001000) || (op == 6'b001100) || (op == 6'b001101);
        lw    = (op == 6'b100011);
        sw    = (op == 6'b101011);
        beq   = (op == 6'b000100);
        jmp   = (op == 6'b000010);
        legal = r_ty || ialu || lw || sw || beq || jmp;
        ext   = ((op == 6'b001100) || (op == 6'b001101)) ? 2'b00 : 2'b01;

        for (int k = 0; k <= iw; k++) begin
            step(fetch_exp(k == iw), 1'b1, 1'b1, k == iw, rb(), 1'b1);
        end

        e = base(3'd1);
        e.alu = c_alu_add; e.srca = 1'b0; e.srcb = 2'b10;
        if (jmp) begin
            e.pcw = 1'b1; e.npc = 2'b10;
        end else if (!legal) begin
            e.ill = 1'b1;
        end
        step(e, 1'b0, 1'b1, rb(), rb(), 1'b1);
        if (jmp || !legal) return;

        e = base(3'd2);
        e.ext = ext; e.srca = 1'b1;
        if (r_ty) begin
            e.srcb = 2'b00; e.alu = r_alu;
        end else if (beq) begin
            e.srcb = 2'b00; e.alu = c_alu_sub; e.pcw = z; e.npc = 2'b01;
        end else begin
            e.srcb = 2'b10;
            e.alu  = (op == 6'b001100) ? c_alu_and : (op == 6'b001101) ? c_alu_or : c_alu_add;
        end
        step(e, 1'b1, 1'b1, rb(), beq ? z : logic'(rb()), 1'b1);
        if (beq) return;

        if (lw || sw) begin
            if (rst_mem) begin
                // Strobes forced low; the reset edge clears err and state.
                step(base(3'd3), 1'b0, 1'b0, 1'b1, rb(), 1'b0);
                exp_err = 1'b0;
                return;
            end
            if (mwt >= IF_TIMEOUT) begin
                for (int k = 0; k < IF_TIMEOUT; k++) begin
                    e = base(3'd3); e.mreq = 1'b1; e.iord = 1'b1; e.ext = ext;
                    e.mw = sw && (k != IF_TIMEOUT - 1);
                    step(e, 1'b1, 1'b0, 1'b0, rb(), 1'b1);
                end
                exp_err = 1'b1;
                return;
            end
            for (int k = 0; k <= mwt; k++) begin
                e = base(3'd3); e.mreq = 1'b1; e.iord = 1'b1; e.mw = sw; e.ext = ext;
                step(e, 1'b1, 1'b0, k == mwt, rb(), 1'b1);
            end
            if (sw) return;
        end

        e = base(3'd4);
        e.rw = 1'b1; e.ext = ext;
        e.rdst = r_ty ? 2'b01 : 2'b00;
        e.wds  = lw   ? 2'b01 : 2'b00;
        step(e, 1'b1, 1'b0, rb(), rb(), 1'b1);
    endtask

    function automatic bit fn_listed(input logic [5:0] f);
        return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010);
    endfunction

    function automatic bit op_listed(input logic [5:0] o);
        return (o == 6'b000000) || (o == 6'b001000) || (o == 6'b001100) || (o == 6'b001101) ||
               (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000100) || (o == 6'b000010);
    endfunction

    task automatic run_random(input int n, input int max_wait);
        logic [5:0] op, fn;
        logic [5:0] fns [5];
        logic [5:0] ops [7];
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        ops = '{6'b001000, 6'b001100, 6'b001101, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
        for (int i = 0; i < n; i++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 10))
                0, 1, 2: begin op = 6'b000000; fn = fns[$urandom_range(0, 4)]; end
                3: begin
                    op = 6'b000000;
                    while (fn_listed(fn)) fn = 6'($urandom);
                end
                4: begin
                    op = 6'($urandom);
                    while (op_listed(op)) op = 6'($urandom);
                end
                default: op = ops[$urandom_range(0, 6)];
            endcase
            run_instr(op, fn, rb(), $urandom_range(0, max_wait), $urandom_range(0, max_wait), 1'b0);
        end
    endtask

    initial begin
        rstn      = 1'b0;
        mem_ready = 1'b0;
        Zero      = 1'b0;
        Op        = '0;
        Funct     = '0;
        @(posedge clk);
        // Reset held: state IF, every strobe low even with mem_ready high.
        step(base(3'd0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, 1'b0);   // j
        run_instr(6'b001101, 6'b011011, 1'b0, 0, 0, 1'b0);   // ori
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 3, 1'b0);   // lw, 3 MEM waits
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, 1'b0);   // beq taken
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, 1'b0);   // beq not taken
        run_instr(6'b111111, 6'b100000, 1'b0, 0, 0, 1'b0);   // illegal opcode
        run_instr(6'b000000, 6'b000001, 1'b0, 0, 0, 1'b0);   // illegal funct
        run_instr(6'b000000, 6'b101010, 1'b0, 2, 0, 1'b0);   // slt, IF waits
        run_instr(6'b101011, 6'b000000, 1'b0, 3, 2, 1'b0);   // sw, waits
        run_instr(6'b001100, 6'b000000, 1'b0, 0, 0, 1'b0);   // andi

        run_random(150, 3);

        // Fetch timeout: IF_TIMEOUT unanswered fetch cycles raise err_o.
        cur_op = 6'b000010;
        for (int k = 0; k < IF_TIMEOUT; k++) begin
            step(fetch_exp(1'b0), 1'b1, 1'b1, 1'b0, rb(), 1'b1);
        end
        exp_err = 1'b1;
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, 1'b0);

        // Data timeout on sw: final waiting cycle must not assert MemWrite.
        run_instr(6'b101011, 6'b000000, 1'b0, 0, IF_TIMEOUT, 1'b0);
        run_instr(6'b001000, 6'b000000, 1'b0, 1, 0, 1'b0);

        // Reset during MEM of sw aborts it and clears err_o.
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 0, 1'b1);
        run_random(20, 3);

        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
